fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction-fetch sequencer and program-counter owner for the 8-bit CPU. It runs a FETCH/DECODE/EXECUTE cycle against instruction memory and holds the instruction register. It drives both data inputs and the select of the per-bit 2:1 next-address multiplexer bank (sequential address vs. branch target), then consumes that bank's output as the next PC. It sits directly upstream of the mux bank and closes the PC loop through it.

## Interface
- ADDR_W, 8, PC / address width
- RESET_PC, 8'h00, PC value loaded on reset
- HALT_OP, 8'hFF, instruction encoding that halts the sequencer
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- run  in  1  level; permits leaving IDLE and starting a new fetch
- mem_rdata  in  8  instruction byte from memory
- mem_ready  in  1  memory read data valid this cycle
- exec_done  in  1  execute unit finished current instruction
- branch_taken  in  1  valid with exec_done; take branch
- branch_target  in  ADDR_W  valid with exec_done
- next_pc  in  ADDR_W  mux bank output X (one bit per mux)
- pc  out  ADDR_W  current PC; also the memory address
- mem_req  out  1  read request
- ir  out  8  instruction register
- ir_valid  out  1  one-cycle pulse, ir is freshly loaded
- seq_addr  out  ADDR_W  pc+1, to mux input S0
- tgt_addr  out  ADDR_W  branch target, to mux input S1
- addr_sel  out  1  mux select S (1 = branch target)
- halted  out  1  sequencer stopped on HALT_OP

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, HALT (registered, one-hot or binary).
- Reset, async and immediate in any state: state=IDLE, pc=RESET_PC, ir=8'h00, ir_valid=0, halted=0. While in reset, mem_req=0, addr_sel=0, tgt_addr=0, seq_addr=RESET_PC+1.
- IDLE: if run=1, go to FETCH next cycle. Otherwise stay.
- FETCH: mem_req=1. Stay until mem_ready=1. In that cycle, ir<=mem_rdata and go to DECODE.
- DECODE: ir_valid=1 for exactly this cycle. If ir==HALT_OP, go to HALT. Otherwise go to EXECUTE.
- EXECUTE: wait for exec_done=1. In the exec_done cycle, pc<=next_pc. Next state is FETCH if run=1, otherwise IDLE.
- HALT: halted=1, mem_req=0, pc holds. Leaves HALT only on reset.
- Combinational outputs:
  - seq_addr = pc+1, modulo 2^ADDR_W: 8'hFF wraps to 8'h00.
  - tgt_addr = branch_target when state==EXECUTE, else 0.
  - addr_sel = (state==EXECUTE) & exec_done & branch_taken.
  - With addr_sel=0 the mux returns seq_addr.
- Dropping run mid-instruction does not abort it. The instruction completes and the sequencer parks in IDLE.
- exec_done, branch_taken, mem_ready outside their states: ignored.
- mem_rdata is sampled only with mem_ready in FETCH.

## Timing
- Minimum instruction period: 3 cycles (FETCH with mem_ready=1, DECODE, EXECUTE with exec_done=1).
- Each cycle of mem_ready or exec_done low adds one cycle.
- pc updates on the clock edge ending the exec_done cycle. The new pc is visible with the first cycle of the following FETCH.
- The combinational path from exec_done/branch_taken/branch_target through the mux bank into the pc register must close in one cycle.
- ir updates on the edge ending the mem_ready cycle. ir_valid is high the following cycle only.

## Test plan
- Reset/IDLE:
  - Assert rst_n=0 mid-EXECUTE -> state IDLE, pc=8'h00, mem_req=0, halted=0 immediately, without waiting for a clock.
  - Hold run=0 -> mem_req stays 0.
- Sequential fetch:
  - Stimulus: run=1; mem_ready=1 and exec_done=1 always; branch_taken=0; mux model attached; mem_rdata=8'h12.
  - Response: pc steps 00->01->02 every 3 cycles; ir_valid pulses once per instruction; ir=8'h12.
- Branch:
  - Stimulus: in EXECUTE with pc=8'h05, drive exec_done=1, branch_taken=1, branch_target=8'hA0.
  - Response: addr_sel=1 and tgt_addr=8'hA0 that cycle; next FETCH shows pc=8'hA0, mem_req=1.
- Wait states:
  - Stimulus: mem_ready low 4 cycles, then exec_done low 2 cycles.
  - Response: instruction takes 9 cycles; ir and pc are stable while waiting.
- Wrap and halt:
  - From pc=8'hFF, a non-branch instruction -> pc=8'h00.
  - Fetch 8'hFF -> HALT after DECODE, halted=1, mem_req=0 forever despite run=1; released only by rst_n.
- Run drop:
  - Deassert run during FETCH -> instruction completes, pc advances once, state IDLE, mem_req=0.
  - Reassert run -> FETCH resumes at the new pc.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch sequencer and program-counter owner.
// Runs FETCH/DECODE/EXECUTE against instruction memory, holds the
// instruction register, and drives the external 2:1 next-address mux bank
// (seq_addr on S0, tgt_addr on S1, addr_sel on S).  The bank output comes
// back on next_pc and is loaded into pc when the execute unit finishes.
//
// Handshake: memory data is taken only in FETCH on a cycle with
// mem_ready=1 (mem_req is held high until then).  exec_done, branch_taken
// and branch_target are taken only in EXECUTE on the exec_done=1 cycle.
// Outside those states the qualifiers are ignored.
module fetch_sequencer #(
   parameter int               ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [7:0]       HALT_OP  = 8'hFF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   input  logic [7:0]        mem_rdata,
   input  logic              mem_ready,
   input  logic              exec_done,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   input  logic [ADDR_W-1:0] next_pc,
   output logic [ADDR_W-1:0] pc,
   output logic              mem_req,
   output logic [7:0]        ir,
   output logic              ir_valid,
   output logic [ADDR_W-1:0] seq_addr,
   output logic [ADDR_W-1:0] tgt_addr,
   output logic              addr_sel,
   output logic              halted,
   output logic [2:0]        dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH   = 3'd1,
      S_DECODE  = 3'd2,
      S_EXECUTE = 3'd3,
      S_HALT    = 3'd4
   } state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [7:0]        r_ir;
   logic              w_in_exec;

   // Sequencer state, program counter and instruction register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_pc    <= RESET_PC;
         r_ir    <= 8'h00;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (run) r_state <= S_FETCH;
            end
            S_FETCH: begin
               if (mem_ready) begin
                  r_ir    <= mem_rdata;
                  r_state <= S_DECODE;
               end
            end
            S_DECODE: begin
               r_state <= (r_ir == HALT_OP) ? S_HALT : S_EXECUTE;
            end
            S_EXECUTE: begin
               // Dropping run never aborts; it only decides where we park.
               if (exec_done) begin
                  r_pc    <= next_pc;
                  r_state <= run ? S_FETCH : S_IDLE;
               end
            end
            S_HALT: begin
               r_state <= S_HALT;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign w_in_exec = (r_state == S_EXECUTE);

   // Outputs decoded from the registered state; mux-bank controls follow
   // the live execute-unit inputs so the pc loop closes in one cycle.
   always_comb begin
      pc        = r_pc;
      ir        = r_ir;
      mem_req   = (r_state == S_FETCH);
      ir_valid  = (r_state == S_DECODE);
      halted    = (r_state == S_HALT);
      seq_addr  = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
      tgt_addr  = w_in_exec ? branch_target : '0;
      addr_sel  = w_in_exec & exec_done & branch_taken;
      dbg_state = r_state;
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer with a behavioural 2:1 next-address mux bank.
module tb_fetch_sequencer;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic [7:0] mem_rdata;
  logic       mem_ready;
  logic       exec_done;
  logic       branch_taken;
  logic [7:0] branch_target;
  logic [7:0] next_pc;
  logic [7:0] pc;
  logic       mem_req;
  logic [7:0] ir;
  logic       ir_valid;
  logic [7:0] seq_addr;
  logic [7:0] tgt_addr;
  logic       addr_sel;
  logic       halted;
  logic [2:0] dbg_state;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  last_op = 8'h00;

  fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .exec_done(exec_done), .branch_taken(branch_taken),
    .branch_target(branch_target), .next_pc(next_pc),
    .pc(pc), .mem_req(mem_req), .ir(ir), .ir_valid(ir_valid),
    .seq_addr(seq_addr), .tgt_addr(tgt_addr), .addr_sel(addr_sel),
    .halted(halted), .dbg_state(dbg_state)
  );

  // next-address mux bank: S=1 selects the branch target
  assign next_pc = addr_sel ? tgt_addr : seq_addr;

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: every ir_valid pulse must match the next expected {pc, ir}
  always @(negedge clk) begin
    if (rst_n && ir_valid) begin
      if (exp_q.size() == 0) begin
        chk("ir_valid_unexpected", {pc, ir}, 16'hxxxx);
      end else begin
        chk("decode_pc_ir", {pc, ir}, exp_q.pop_front());
      end
    end
  end

  // advance to the next cycle and wait (bounded) for a FETCH cycle
  task automatic wait_fetch();
    int n;
    n = 0;
    @(negedge clk);
    exec_done     = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 8'h5A;
    while (!mem_req && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!mem_req) chk("fetch_timeout", 16'(mem_req), 16'd1);
  endtask

  // drive one instruction through FETCH/DECODE/EXECUTE
  task automatic do_instr(input logic [7:0] op, input logic [7:0] exp_pc,
                          input int mw, input int ew, input logic br,
                          input logic [7:0] tgt, input int exp_cyc,
                          input logic drop_run, input logic hold_exec);
    time t0;
    int cyc;
    logic [7:0] s;
    wait_fetch();
    t0 = $time;
    chk("fetch_pc", 16'(pc), 16'(exp_pc));
    chk("fetch_tgt_zero", 16'(tgt_addr), 16'h0000);
    if (drop_run) run = 1'b0;
    exp_q.push_back({exp_pc, op});
    mem_rdata = op;
    for (int k = 0; k < mw; k++) begin
      mem_ready = 1'b0;
      @(negedge clk);
      chk("fwait_pc", 16'(pc), 16'(exp_pc));
      chk("fwait_ir", 16'(ir), 16'(last_op));
      chk("fwait_req", 16'(mem_req), 16'd1);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    mem_rdata = 8'hEE;
    last_op = op;
    if (op == 8'hFF) return;
    @(negedge clk);
    chk("exec_state", 16'(dbg_state), 16'd3);
    for (int k = 0; k < ew; k++) begin
      exec_done    = 1'b0;
      branch_taken = 1'b1;
      @(negedge clk);
      chk("ewait_pc", 16'(pc), 16'(exp_pc));
      chk("ewait_ir", 16'(ir), 16'(op));
      chk("ewait_sel", 16'(addr_sel), 16'd0);
    end
    branch_taken = 1'b0;
    if (hold_exec) return;
    exec_done     = 1'b1;
    branch_taken  = br;
    branch_target = tgt;
    #1;
    s = exp_pc + 8'd1;
    chk("exec_addr_sel", 16'(addr_sel), 16'(br));
    chk("exec_tgt_addr", 16'(tgt_addr), 16'(tgt));
    chk("exec_seq_addr", 16'(seq_addr), 16'(s));
    cyc = int'(($time - t0) / 10) + 1;
    chk("instr_cycles", 16'(cyc), 16'(exp_cyc));
  endtask

  // main stimulus
  initial begin
    rst_n = 1'b0; run = 1'b0; mem_rdata = 8'h00; mem_ready = 1'b0;
    exec_done = 1'b0; branch_taken = 1'b0; branch_target = 8'h33;
    #12;
    chk("rst_pc", 16'(pc), 16'h0000);
    chk("rst_ir", 16'(ir), 16'h0000);
    chk("rst_ctl", {11'd0, mem_req, ir_valid, halted, addr_sel, 1'b0}, 16'h0000);
    chk("rst_tgt", 16'(tgt_addr), 16'h0000);
    chk("rst_seq", 16'(seq_addr), 16'h0001);
    chk("rst_state", 16'(dbg_state), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_no_req", 16'(mem_req), 16'd0);
    end
    run = 1'b1;

    // sequential fetch, 3-cycle instructions
    do_instr(8'h12, 8'h00, 0, 0, 1'b0, 8'h00, 3, 1'b0, 1'b0);
    do_instr(8'h12, 8'h01, 0, 0, 1'b0, 8'h00, 3, 1'b0, 1'b0);
    do_instr(8'h12, 8'h02, 0, 0, 1'b0, 8'h00, 3, 1'b0, 1'b0);
    do_instr(8'h12, 8'h03, 0, 0, 1'b0, 8'h00, 3, 1'b0, 1'b0);
    do_instr(8'h12, 8'h04, 0, 0, 1'b0, 8'h00, 3, 1'b0, 1'b0);
    // branch from 05 to A0
    do_instr(8'h12, 8'h05, 0, 0, 1'b1, 8'hA0, 3, 1'b0, 1'b0);
    // wait states: 4 memory, 2 execute -> 9 cycles
    do_instr(8'h34, 8'hA0, 4, 2, 1'b0, 8'h11, 9, 1'b0, 1'b0);
    // branch to FF, then a plain instruction wraps pc to 00
    do_instr(8'h12, 8'hA1, 0, 0, 1'b1, 8'hFF, 3, 1'b0, 1'b0);
    do_instr(8'h56, 8'hFF, 0, 1, 1'b0, 8'h22, 4, 1'b0, 1'b0);
    // run dropped during FETCH: instruction completes, parks in IDLE
    do_instr(8'h78, 8'h00, 1, 0, 1'b0, 8'h00, 4, 1'b1, 1'b0);
    @(negedge clk);
    exec_done = 1'b0;
    chk("drop_state", 16'(dbg_state), 16'd0);
    chk("drop_pc", 16'(pc), 16'h0001);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("drop_no_req", 16'(mem_req), 16'd0);
    end
    run = 1'b1;
    // fetch HALT_OP at the resumed pc
    do_instr(8'hFF, 8'h01, 0, 0, 1'b0, 8'h00, 0, 1'b0, 1'b0);
    @(negedge clk);
    chk("halt_flag", 16'(halted), 16'd1);
    chk("halt_state", 16'(dbg_state), 16'd4);
    for (int i = 0; i < 6; i++) begin
      mem_ready = 1'b1; exec_done = 1'b1;
      @(negedge clk);
      chk("halt_no_req", {8'd0, 7'd0, mem_req}, 16'h0000);
      chk("halt_hold", {halted, 7'd0, pc}, 16'h8001);
    end
    mem_ready = 1'b0; exec_done = 1'b0;
    // reset releases HALT immediately
    #2 rst_n = 1'b0;
    #1;
    chk("halt_rst_flag", 16'(halted), 16'd0);
    chk("halt_rst_state", 16'(dbg_state), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_op = 8'h00;
    // branch to 40, then reset asynchronously in the middle of EXECUTE
    do_instr(8'h12, 8'h00, 0, 0, 1'b1, 8'h40, 3, 1'b0, 1'b0);
    do_instr(8'h9A, 8'h40, 0, 0, 1'b0, 8'h00, 0, 1'b0, 1'b1);
    chk("mid_exec_pc", 16'(pc), 16'h0040);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_state", 16'(dbg_state), 16'd0);
    chk("async_rst_pc", 16'(pc), 16'h0000);
    chk("async_rst_ctl", {14'd0, mem_req, halted}, 16'h0000);
    @(negedge clk);
    chk("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global time limit
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
